// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch/issue front end.
//   - Opcode constants for the instructions the front end cares about.
//   - fetch_state_t: fetch sequencer states.
package fetch_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch front end (purely combinational).
// Optional feature macro: FETCH_JUMP_EN (adds the j-instruction target path).
// Ports:
//   pc_plus4  in   PC_W  PC+4 of the instruction being issued
//   imm       in   16    branch offset in words (sign-extended here)
//   branch    in   1     Branch from the control decoder
//   zero      in   1     ALU Zero
//   op        in   6     opcode of the instruction being issued
//   target    in   26    IR[25:0], jump target in words
//   next_pc   out  PC_W  address of the next instruction
module fetch_next_pc #(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc_plus4,
    input  logic [15:0]     imm,
    input  logic            branch,
    input  logic            zero,
    input  logic [5:0]      op,
    input  logic [25:0]     target,
    output logic [PC_W-1:0] next_pc
);
    import fetch_pkg::*;

    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] seq_or_br;

    // Word offset, sign-extended and scaled to bytes; wraps modulo 2^PC_W.
    assign br_off    = {{(PC_W-18){imm[15]}}, imm, 2'b00};
    assign seq_or_br = (branch && zero) ? (pc_plus4 + br_off) : pc_plus4;

`ifdef FETCH_JUMP_EN
    // Jump keeps the 256 MB region of the delay-free successor and overrides any branch.
    assign next_pc = (op == OP_J) ? {pc_plus4[PC_W-1:28], target, 2'b00} : seq_or_br;
`else
    logic unused_jump;
    assign unused_jump = ^{op, target};
    assign next_pc     = seq_or_br;
`endif

endmodule

// File: rtl/instr_fetch_issue.sv
// Instruction-side front end: owns PC and IR, fetches over a req/valid
// handshake, presents decoded fields and selects the next PC on issue.
// Optional feature macro: FETCH_JUMP_EN (handled in fetch_next_pc).
// Ports:
//   clk, rst                  clock, async active-high reset
//   imem_req/imem_addr        one-cycle fetch request and address (= PC)
//   imem_valid/imem_rdata     fetch response pulse and instruction word
//   issue_valid/issue_ready   issue handshake to the datapath
//   op, rs, rt, rd, funct,imm decoded IR fields
//   pc_plus4                  PC+4 of the issued instruction
//   branch, zero              next-PC controls, used on the issue handshake only
//
// state | meaning
// FETCH | imem_req asserted for one cycle with imem_addr = PC
// WAIT  | waiting for imem_valid; response word captured into IR
// ISSUE | IR presented; on issue_ready PC advances and fetch restarts
module instr_fetch_issue #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [5:0]      op,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [5:0]      funct,
    output logic [15:0]     imm,
    output logic [PC_W-1:0] pc_plus4,
    input  logic            branch,
    input  logic            zero
);
    import fetch_pkg::*;

    fetch_state_t    state, next_state;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic [PC_W-1:0] next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:   next_state = WAIT;
            WAIT:    if (imem_valid)  next_state = ISSUE;
            ISSUE:   if (issue_ready) next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // State is already FETCH while rst is high, so the request is masked by
    // rst to keep it low during reset and let it rise on the first clock after.
    always_comb begin
        imem_req    = (state == FETCH) && !rst;
        issue_valid = (state == ISSUE);
    end

    // Responses outside WAIT are protocol errors and never touch IR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            ir <= '0;
        end else begin
            if (state == WAIT && imem_valid)
                ir <= imem_rdata;
            if (state == ISSUE && issue_ready)
                pc <= next_pc;
        end
    end

    fetch_next_pc #(.PC_W(PC_W)) u_next_pc (
        .pc_plus4 (pc_plus4),
        .imm      (ir[15:0]),
        .branch   (branch),
        .zero     (zero),
        .op       (ir[31:26]),
        .target   (ir[25:0]),
        .next_pc  (next_pc)
    );

    assign imem_addr = pc;
    assign pc_plus4  = pc + {{(PC_W-3){1'b0}}, 3'd4};
    assign op        = ir[31:26];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign funct     = ir[5:0];
    assign imm       = ir[15:0];

endmodule
